// File: rtl/stepper_move_sequencer.sv
// -----------------------------------------------------------------------------
// stepper_move_sequencer
//
// Executes relative moves on a 4-phase unipolar stepper (single-coil drive).
// A move command (step count, direction, step period) is accepted in IDLE,
// executed in RUN at one phase advance per period, and closed in FINISH.
// After a move the current coil stays energized (holding torque) for
// HOLD_CYCLES idle cycles and is then released to save power.
//
// Parameters
//   MIN_PERIOD   minimum clock cycles per step; slower commands pass through,
//                faster ones are clamped to this value (must be >= 1)
//   HOLD_CYCLES  idle cycles after a move before the coils are released (>= 1)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   cmd_valid     move command present
//   cmd_ready     high only in IDLE; command accepted when valid & ready
//   cmd_steps     unsigned step count (0 = no motion, done still pulses)
//   cmd_dir       1 = forward A->B->C->D, 0 = reverse
//   cmd_period    clock cycles per step (clamped up to MIN_PERIOD)
//   abort         stop the current move (ignored outside RUN)
//   bobinasMotor  one-hot coil drive, bit0 = A .. bit3 = D, 0000 = released
//   busy          a move is in progress (RUN / FINISH)
//   done          one-cycle pulse on normal completion
//   aborted       one-cycle pulse when a move ends by abort
//   position      signed step count, wraps modulo 2^16
//   ledDirecc     direction of the last accepted command
// -----------------------------------------------------------------------------
module stepper_move_sequencer #(
  parameter int unsigned MIN_PERIOD  = 100000,
  parameter int unsigned HOLD_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [15:0]        cmd_steps,
  input  logic               cmd_dir,
  input  logic [23:0]        cmd_period,
  input  logic               abort,
  output logic [3:0]         bobinasMotor,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic signed [15:0] position,
  output logic               ledDirecc
);

  localparam logic [23:0] MIN_P = 24'(MIN_PERIOD);

  // Hold counter runs 0 .. HOLD_CYCLES-1; one bit minimum so the width is legal.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [1:0]          r_phase;        // 0 = A, 1 = B, 2 = C, 3 = D
  logic [15:0]         r_position;
  logic [15:0]         r_steps_left;
  logic [23:0]         r_period;
  logic                r_dir;
  logic [23:0]         r_step_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_hold_active;  // coils energized and waiting to release
  logic [3:0]          r_coils;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;
  logic                r_led;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                w_accept;
  logic                w_zero_cmd;
  logic [23:0]         w_period_clamped;
  logic [23:0]         w_period_last;
  logic                w_step_event;
  logic                w_last_step;
  logic [1:0]          w_phase_next;
  logic [15:0]         w_position_next;
  logic [3:0]          w_phase_onehot;
  logic [3:0]          w_next_onehot;
  logic                w_hold_expired;

  assign w_accept         = cmd_valid && (r_state == ST_IDLE);
  assign w_zero_cmd       = (cmd_steps == 16'd0);
  assign w_period_clamped = (cmd_period < MIN_P) ? MIN_P : cmd_period;

  // The step timer is cleared on acceptance, so comparing against period-1
  // places the first step exactly one period after the accepting edge.
  assign w_period_last    = r_period - 24'd1;
  assign w_step_event     = (r_step_cnt == w_period_last);
  assign w_last_step      = (r_steps_left == 16'd1);

  // Two-bit phase index wraps naturally: D+1 = A, A-1 = D.
  assign w_phase_next     = r_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);
  assign w_position_next  = r_dir ? (r_position + 16'd1) : (r_position - 16'd1);

  assign w_hold_expired   = (r_hold_cnt == HOLD_LAST);

  for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
    assign w_phase_onehot[gi] = (r_phase == 2'(gi));
    assign w_next_onehot[gi]  = (w_phase_next == 2'(gi));
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= 2'd0;
      r_position    <= 16'd0;
      r_steps_left  <= 16'd0;
      r_period      <= MIN_P;
      r_dir         <= 1'b0;
      r_step_cnt    <= 24'd0;
      r_hold_cnt    <= '0;
      r_hold_active <= 1'b0;
      r_coils       <= 4'b0000;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_led         <= 1'b0;
    end else begin
      // Status pulses default low; each is raised for exactly one cycle.
      r_done    <= 1'b0;
      r_aborted <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Holding torque: count idle cycles, then release the coils. The
          // phase index is kept so the next move resumes without a skip.
          if (r_hold_active) begin
            if (w_hold_expired) begin
              r_hold_active <= 1'b0;
              r_hold_cnt    <= '0;
              r_coils       <= 4'b0000;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end

          // Accept logic is placed after the hold logic so that a command
          // arriving on the release cycle keeps the coils energized.
          if (w_accept) begin
            r_led <= cmd_dir;
            if (w_zero_cmd) begin
              // Nothing to move: report completion, leave the hold timer alone.
              r_done <= 1'b1;
            end else begin
              r_steps_left  <= cmd_steps;
              r_dir         <= cmd_dir;
              r_period      <= w_period_clamped;
              r_step_cnt    <= 24'd0;
              r_busy        <= 1'b1;
              r_coils       <= w_phase_onehot;
              r_hold_active <= 1'b0;
              r_hold_cnt    <= '0;
              r_state       <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (abort) begin
            // Abort has priority over a coincident step event.
            r_aborted     <= 1'b1;
            r_busy        <= 1'b0;
            r_hold_active <= 1'b1;
            r_hold_cnt    <= '0;
            r_state       <= ST_IDLE;
          end else if (w_step_event) begin
            r_phase      <= w_phase_next;
            r_coils      <= w_next_onehot;
            r_position   <= w_position_next;
            r_steps_left <= r_steps_left - 16'd1;
            r_step_cnt   <= 24'd0;
            if (w_last_step) begin
              r_state <= ST_FINISH;
            end
          end else begin
            r_step_cnt <= r_step_cnt + 24'd1;
          end
        end

        ST_FINISH: begin
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_hold_active <= 1'b1;
          r_hold_cnt    <= '0;
          r_state       <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready    = (r_state == ST_IDLE);
  assign bobinasMotor = r_coils;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign position     = r_position;
  assign ledDirecc    = r_led;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for stepper_move_sequencer.
// u_dut uses MIN_PERIOD=4, HOLD_CYCLES=8. u_wrap uses MIN_PERIOD=1 so the
// position wrap-around can be reached in a few tens of thousands of cycles.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_stepper_move_sequencer;

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [15:0]        cmd_steps;
  logic               cmd_dir;
  logic [23:0]        cmd_period;
  logic               abort;
  logic [3:0]         coils;
  logic               busy;
  logic               done;
  logic               aborted;
  logic signed [15:0] position;
  logic               led;

  logic               w2_valid;
  logic               w2_ready;
  logic [15:0]        w2_steps;
  logic               w2_dir;
  logic [23:0]        w2_period;
  logic               w2_abort;
  logic [3:0]         w2_coils;
  logic               w2_busy;
  logic               w2_done;
  logic               w2_aborted;
  logic signed [15:0] w2_position;
  logic               w2_led;

  int errors = 0;
  int checks = 0;

  stepper_move_sequencer #(.MIN_PERIOD(4), .HOLD_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_period(cmd_period),
    .abort(abort), .bobinasMotor(coils), .busy(busy), .done(done),
    .aborted(aborted), .position(position), .ledDirecc(led)
  );

  stepper_move_sequencer #(.MIN_PERIOD(1), .HOLD_CYCLES(8)) u_wrap (
    .clk(clk), .rst(rst), .cmd_valid(w2_valid), .cmd_ready(w2_ready),
    .cmd_steps(w2_steps), .cmd_dir(w2_dir), .cmd_period(w2_period),
    .abort(w2_abort), .bobinasMotor(w2_coils), .busy(w2_busy), .done(w2_done),
    .aborted(w2_aborted), .position(w2_position), .ledDirecc(w2_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for one cycle; returns 1 unit after the accepting edge.
  task automatic issue_cmd(input logic [15:0] s, input logic d, input logic [23:0] p);
    $display("cmd: steps=%0d dir=%0d period=%0d", s, d, p);
    cmd_steps = s; cmd_dir = d; cmd_period = p; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (coils !== 4'b0000) begin errors++; $display("FAIL reset_coils: got %b want 0000", coils); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b done=%b aborted=%b want 000", busy, done, aborted); end
    checks++; if (position !== 16'sd0) begin errors++; $display("FAIL reset_position: got %0d want 0", position); end
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led: got %b want 0", led); end
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    checks++; if (coils !== 4'b0000) begin errors++; $display("FAIL reset_released: got %b want 0000", coils); end
  endtask

  // steps=3 fwd period=5: coil changes at acceptance+5/+10/+15, done at +16.
  task automatic test_forward_move();
    int dn = 0;
    issue_cmd(16'd3, 1'b1, 24'd5);
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL fwd_start: busy=%b ready=%b want 1 0", busy, cmd_ready); end
    checks++; if (coils !== 4'b0001) begin errors++; $display("FAIL fwd_energize: got %b want 0001", coils); end
    checks++; if (led !== 1'b1) begin errors++; $display("FAIL fwd_led: got %b want 1", led); end
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (done === 1'b1) dn++;
      if (k == 4) begin checks++; if (coils !== 4'b0001) begin errors++; $display("FAIL fwd_early: got %b want 0001", coils); end end
      if (k == 5) begin checks++; if (coils !== 4'b0010) begin errors++; $display("FAIL fwd_step1: got %b want 0010", coils); end end
      if (k == 10) begin checks++; if (coils !== 4'b0100) begin errors++; $display("FAIL fwd_step2: got %b want 0100", coils); end end
      if (k == 15) begin checks++; if (coils !== 4'b1000 || busy !== 1'b1) begin errors++; $display("FAIL fwd_step3: coils=%b busy=%b want 1000 1", coils, busy); end end
      if (k == 16) begin
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fwd_done: done=%b busy=%b want 1 0", done, busy); end
        checks++; if (position !== 16'sd3) begin errors++; $display("FAIL fwd_position: got %0d want 3", position); end
      end
    end
    checks++; if (dn != 1) begin errors++; $display("FAIL fwd_done_count: got %0d want 1", dn); end
  endtask

  // Period 1 clamps to 4; reverse from A goes A -> D -> C.
  task automatic test_clamp_reverse();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    issue_cmd(16'd2, 1'b0, 24'd1);
    checks++; if (coils !== 4'b0001) begin errors++; $display("FAIL rev_energize: got %b want 0001", coils); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 3) begin checks++; if (coils !== 4'b0001) begin errors++; $display("FAIL rev_clamp_early: got %b want 0001", coils); end end
      if (k == 4) begin checks++; if (coils !== 4'b1000) begin errors++; $display("FAIL rev_step1: got %b want 1000", coils); end end
      if (k == 7) begin checks++; if (coils !== 4'b1000) begin errors++; $display("FAIL rev_clamp_mid: got %b want 1000", coils); end end
      if (k == 8) begin checks++; if (coils !== 4'b0100) begin errors++; $display("FAIL rev_step2: got %b want 0100", coils); end end
      if (k == 9) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rev_done: got %b want 1", done); end
        checks++; if (position !== -16'sd2) begin errors++; $display("FAIL rev_position: got %0d want -2", position); end
      end
    end
  endtask

  // Runs straight after test_clamp_reverse (sampling point = done edge + 1).
  task automatic test_hold_release();
    for (int k = 0; k < 7; k++) tick();
    checks++; if (coils !== 4'b0100) begin errors++; $display("FAIL hold_still_on: got %b want 0100", coils); end
    tick();
    checks++; if (coils !== 4'b0000) begin errors++; $display("FAIL hold_release: got %b want 0000", coils); end
    issue_cmd(16'd1, 1'b1, 24'd4);
    checks++; if (coils !== 4'b0100) begin errors++; $display("FAIL hold_reenergize: got %b want 0100", coils); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) begin checks++; if (coils !== 4'b0100) begin errors++; $display("FAIL hold_wait: got %b want 0100", coils); end end
      if (k == 4) begin checks++; if (coils !== 4'b1000) begin errors++; $display("FAIL hold_next_phase: got %b want 1000", coils); end end
      if (k == 5) begin checks++; if (done !== 1'b1 || position !== -16'sd1) begin errors++; $display("FAIL hold_done: done=%b pos=%0d want 1 -1", done, position); end end
    end
  endtask

  // From phase D, position -1: steps at +4 (A, 0) and +8 (B, 1); abort on the
  // cycle ending at +12 suppresses the third step.
  task automatic test_abort();
    int dn = 0;
    issue_cmd(16'd10, 1'b1, 24'd4);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (done === 1'b1) dn++;
      if (k == 4) begin checks++; if (coils !== 4'b0001 || position !== 16'sd0) begin errors++; $display("FAIL abort_step1: coils=%b pos=%0d want 0001 0", coils, position); end end
      if (k == 8) begin checks++; if (coils !== 4'b0010 || position !== 16'sd1) begin errors++; $display("FAIL abort_step2: coils=%b pos=%0d want 0010 1", coils, position); end end
      if (k == 11) begin checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (done === 1'b1) dn++;
    checks++; if (aborted !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_pulse: aborted=%b busy=%b ready=%b want 1 0 1", aborted, busy, cmd_ready); end
    checks++; if (coils !== 4'b0010 || position !== 16'sd1) begin errors++; $display("FAIL abort_wins: coils=%b pos=%0d want 0010 1", coils, position); end
    tick();
    if (done === 1'b1) dn++;
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL abort_one_cycle: got %b want 0", aborted); end
    checks++; if (dn != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses want 0", dn); end
    // abort in IDLE has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (aborted !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: aborted=%b busy=%b ready=%b want 0 0 1", aborted, busy, cmd_ready); end
  endtask

  // Runs 3 cycles after the abort edge; the hold timer started at the abort
  // must not be restarted, so release lands at abort edge + 8.
  task automatic test_zero_steps();
    issue_cmd(16'd0, 1'b0, 24'd4);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_done: done=%b busy=%b ready=%b want 1 0 1", done, busy, cmd_ready); end
    checks++; if (coils !== 4'b0010 || position !== 16'sd1) begin errors++; $display("FAIL zero_no_motion: coils=%b pos=%0d want 0010 1", coils, position); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_pulse_end: done=%b busy=%b want 0 0", done, busy); end
    tick(); tick(); tick();
    checks++; if (coils !== 4'b0010) begin errors++; $display("FAIL zero_hold_on: got %b want 0010", coils); end
    tick();
    checks++; if (coils !== 4'b0000) begin errors++; $display("FAIL zero_hold_not_restarted: got %b want 0000", coils); end
  endtask

  task automatic test_reset_mid_move();
    int ev = 0;
    issue_cmd(16'd5, 1'b1, 24'd4);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin errors++; $display("FAIL rstmid_flags: busy=%b done=%b aborted=%b want 000", busy, done, aborted); end
    checks++; if (coils !== 4'b0000 || position !== 16'sd0) begin errors++; $display("FAIL rstmid_state: coils=%b pos=%0d want 0000 0", coils, position); end
    checks++; if (led !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_led_ready: led=%b ready=%b want 0 1", led, cmd_ready); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1 || aborted === 1'b1 || busy === 1'b1 || coils !== 4'b0000) ev++;
    end
    checks++; if (ev != 0) begin errors++; $display("FAIL rstmid_discarded: %0d cycles with activity want 0", ev); end
  endtask

  // Wrap-around on the MIN_PERIOD=1 instance (one step per cycle).
  task automatic test_wrap();
    logic [15:0] t_steps [3];
    logic        t_dir   [3];
    logic [15:0] t_pos   [3];
    logic [3:0]  t_coils [3];
    t_steps[0] = 16'd32766; t_dir[0] = 1'b1; t_pos[0] = 16'd32766; t_coils[0] = 4'b0100;
    t_steps[1] = 16'd3;     t_dir[1] = 1'b1; t_pos[1] = 16'h8001;  t_coils[1] = 4'b0010;
    t_steps[2] = 16'd2;     t_dir[2] = 1'b0; t_pos[2] = 16'h7FFF;  t_coils[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      logic got;
      got = 1'b0;
      $display("wrap cmd: steps=%0d dir=%0d expect pos=%0d", t_steps[i], t_dir[i], $signed(t_pos[i]));
      w2_steps = t_steps[i]; w2_dir = t_dir[i]; w2_period = 24'd1; w2_valid = 1'b1;
      tick();
      w2_valid = 1'b0;
      for (int n = 0; n < 40000 && !got; n++) begin
        tick();
        if (w2_done === 1'b1) got = 1'b1;
      end
      checks++; if (!got) begin errors++; $display("FAIL wrap_timeout[%0d]: no done within 40000 cycles", i); end
      checks++; if (w2_position !== t_pos[i]) begin errors++; $display("FAIL wrap_position[%0d]: got %0d want %0d", i, w2_position, $signed(t_pos[i])); end
      checks++; if (w2_coils !== t_coils[i] || w2_busy !== 1'b0 || w2_ready !== 1'b1) begin errors++; $display("FAIL wrap_end[%0d]: coils=%b busy=%b ready=%b want %b 0 1", i, w2_coils, w2_busy, w2_ready, t_coils[i]); end
      checks++; if (w2_aborted !== 1'b0 || w2_led !== t_dir[i]) begin errors++; $display("FAIL wrap_flags[%0d]: aborted=%b led=%b want 0 %b", i, w2_aborted, w2_led, t_dir[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_steps = 16'd0; cmd_dir = 1'b0; cmd_period = 24'd0; abort = 1'b0;
    w2_valid = 1'b0; w2_steps = 16'd0; w2_dir = 1'b0; w2_period = 24'd0; w2_abort = 1'b0;
    test_reset();
    test_forward_move();
    test_clamp_reverse();
    test_hold_release();
    test_abort();
    test_zero_steps();
    test_reset_mid_move();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
